// File: rtl/sha256_block_driver.sv
// Bus initiator for the sha256 MMIO peripheral: block in, INIT/NEXT, poll, digest out.
// Optional poll timeout with err pulse when SHA256_DRV_TIMEOUT_EN is defined.
module sha256_block_driver #(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TIMEOUT_W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_init,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         busy,
    output logic         err,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data
);

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_BLOCK  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST = 8'h20;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TIMEOUT_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit TIMEOUT_W");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PRE_POLL, S_WRITE, S_CTRL, S_POLL, S_READ, S_OUT
    } state_e;

    state_e         state_q;
    logic [511:0]   blk_q;
    logic           init_q;
    logic [3:0]     wr_idx_q;
    logic [2:0]     rd_idx_q;
    logic           cs_q, we_q;
    logic [7:0]     addr_q;
    logic [31:0]    wdata_q;
    logic [255:0]   dig_q;
    logic           dig_valid_q, blk_ready_q, busy_q;
    logic           polling;
    logic           poll_expire;

    assign polling = (state_q == S_PRE_POLL) || (state_q == S_POLL);

`ifdef SHA256_DRV_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] poll_cnt_q;
    logic                 err_q;

    assign poll_expire = (poll_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    // Counter idles at zero outside the poll states, so each poll phase starts fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= polling && !read_data[0] && poll_expire;
            if (polling && !read_data[0]) poll_cnt_q <= poll_cnt_q + 1'b1;
            else                          poll_cnt_q <= '0;
        end
    end

    assign err = err_q;
`else
    assign poll_expire = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            init_q      <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dig_q       <= '0;
            dig_valid_q <= 1'b0;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (blk_valid) begin
                        blk_q       <= blk_data;
                        init_q      <= blk_init;
                        state_q     <= S_PRE_POLL;
                        blk_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cs_q        <= 1'b1;
                        addr_q      <= ADDR_STATUS;
                    end
                end
                S_PRE_POLL, S_POLL: begin
                    if (read_data[0]) begin
                        if (state_q == S_PRE_POLL) begin
                            // Block is shifted out MSB-first, so word 0 goes first.
                            state_q <= S_WRITE;
                            we_q    <= 1'b1;
                            addr_q  <= ADDR_BLOCK;
                            wdata_q <= blk_q[511:480];
                            blk_q   <= {blk_q[479:0], 32'h0};
                        end else begin
                            state_q <= S_READ;
                            addr_q  <= ADDR_DIGEST;
                        end
                    end else if (poll_expire) begin
                        state_q     <= S_IDLE;
                        cs_q        <= 1'b0;
                        addr_q      <= '0;
                        blk_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                S_WRITE: begin
                    wr_idx_q <= wr_idx_q + 4'd1;
                    if (wr_idx_q == 4'd15) begin
                        state_q <= S_CTRL;
                        addr_q  <= ADDR_CTRL;
                        wdata_q <= init_q ? 32'h1 : 32'h2;
                    end else begin
                        addr_q  <= {4'h1, wr_idx_q + 4'd1};
                        wdata_q <= blk_q[511:480];
                        blk_q   <= {blk_q[479:0], 32'h0};
                    end
                end
                S_CTRL: begin
                    state_q <= S_POLL;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    addr_q  <= ADDR_STATUS;
                end
                S_READ: begin
                    // After eight shifts h0 lands in the top word.
                    dig_q    <= {dig_q[223:0], read_data};
                    rd_idx_q <= rd_idx_q + 3'd1;
                    if (rd_idx_q == 3'd7) begin
                        state_q     <= S_OUT;
                        cs_q        <= 1'b0;
                        addr_q      <= '0;
                        dig_valid_q <= 1'b1;
                    end else begin
                        addr_q <= {5'b00100, rd_idx_q + 3'd1};
                    end
                end
                S_OUT: begin
                    if (dig_ready) begin
                        state_q     <= S_IDLE;
                        dig_valid_q <= 1'b0;
                        blk_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign blk_ready  = blk_ready_q;
    assign dig_valid  = dig_valid_q;
    assign dig_data   = dig_q;
    assign busy       = busy_q;
    assign cs         = cs_q;
    assign we         = we_q;
    assign address    = addr_q;
    assign write_data = wdata_q;

endmodule

// File: tb/tb_sha256_block_driver.sv
// Bench for sha256_block_driver: behavioural sha256 peripheral, bus monitor, digest scoreboard.
module tb_sha256_block_driver;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h18};
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] M1_BLK = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M2_BLK = {480'h0, 32'h000001c0};
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst, p_rst, stuck;
    logic         blk_valid, blk_ready, blk_init;
    logic [511:0] blk_data;
    logic         dig_valid, dig_ready;
    logic [255:0] dig_data;
    logic         busy, err, cs, we;
    logic [7:0]   address;
    logic [31:0]  write_data, read_data;

    int           n_vec = 0, n_err = 0;
    int           cyc = 0, hs_cyc = 0;
    logic [511:0] cur_blk = '0;
    logic [255:0] sb_q[$];
    logic [31:0]  ctrl_q[$];

    sha256_block_driver dut (
        .clk(clk), .reset(rst),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_init(blk_init),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
        .busy(busy), .err(err),
        .cs(cs), .we(we), .address(address), .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [31:0] word_at(input logic [511:0] b, input int i);
        logic [511:0] t;
        t = b >> (32 * (15 - i));
        return t[31:0];
    endfunction

    // Peripheral: busy for 65 cycles after an INIT/NEXT write, digest readable when ready.
    logic [31:0]  p_blk [16];
    logic [255:0] p_h;
    logic         p_ready;
    int           p_cnt;

    always @(posedge clk) begin
        if (p_rst) begin
            p_ready <= 1'b1;
            p_cnt   <= 0;
            p_h     <= '0;
        end else if (cs && we) begin
            if (address[7:4] == 4'h1) p_blk[address[3:0]] <= write_data;
            else if (address == 8'h08 && (write_data[0] || write_data[1])) begin
                p_h     <= sha_comp(write_data[0] ? IV : p_h,
                                    {p_blk[0], p_blk[1], p_blk[2], p_blk[3], p_blk[4], p_blk[5], p_blk[6], p_blk[7],
                                     p_blk[8], p_blk[9], p_blk[10], p_blk[11], p_blk[12], p_blk[13], p_blk[14], p_blk[15]});
                p_ready <= 1'b0;
                p_cnt   <= 64;
            end
        end else if (!p_ready) begin
            if (p_cnt == 0) p_ready <= 1'b1;
            else            p_cnt   <= p_cnt - 1;
        end
    end

    always_comb begin
        logic [255:0] sh;
        sh = p_h >> (32 * (7 - int'(address[2:0])));
        read_data = '0;
        if (address == 8'h09)             read_data = {31'h0, p_ready & ~stuck};
        else if (address[7:3] == 5'b00100) read_data = sh[31:0];
    end

    // Bus monitor: block writes ascend 0x10..0x1F, then exactly one CTRL write.
    logic [7:0] exp_waddr = 8'h10;
    always @(negedge clk) begin
        if (rst) exp_waddr = 8'h10;
        else begin
            chk("we_without_cs", we & ~cs, 1'b0);
            chk("wdata_without_we", ~we & (|write_data), 1'b0);
            if (cs && we) begin
                if (address[7:4] == 4'h1 && exp_waddr[7:4] == 4'h1) begin
                    chk("blk_waddr", address, exp_waddr);
                    chk("blk_wdata", write_data, word_at(cur_blk, int'(exp_waddr) - 16));
                    exp_waddr = exp_waddr + 8'h1;
                end else begin
                    chk("ctrl_addr", address, 8'h08);
                    chk("ctrl_after_16", exp_waddr, 8'h20);
                    if (ctrl_q.size() == 0) chk("ctrl_unexpected", 1'b1, 1'b0);
                    else                    chk("ctrl_data", write_data, ctrl_q.pop_front());
                    exp_waddr = 8'h10;
                end
            end else if (cs) begin
                chk("read_addr", (address == 8'h09) || (address[7:3] == 5'b00100), 1'b1);
            end
        end
    end

    task automatic send_blk(input logic [511:0] b, input logic init, input logic [255:0] exp,
                            input bit expect_out);
        int n = 0;
        blk_data  = b;
        blk_init  = init;
        blk_valid = 1'b1;
        while (!blk_ready && n < 5000) begin @(negedge clk); n++; end
        if (!blk_ready) begin
            chk("accept_timeout", 1'b0, 1'b1);
            blk_valid = 1'b0;
            return;
        end
        hs_cyc  = cyc;
        cur_blk = b;
        if (expect_out) begin
            sb_q.push_back(exp);
            ctrl_q.push_back(init ? 32'h1 : 32'h2);
        end
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = {16{$urandom()}};
        chk("accept_busy", busy, 1'b1);
        chk("accept_blk_ready", blk_ready, 1'b0);
    endtask

    task automatic recv_dig(input int stall, input int exp_lat);
        int n = 0;
        logic [255:0] snap, exp;
        while (!dig_valid && n < 3000) begin @(negedge clk); n++; end
        if (!dig_valid) begin
            chk("dig_timeout", 1'b0, 1'b1);
            return;
        end
        if (exp_lat != 0) chk("latency", cyc - hs_cyc, exp_lat);
        else              chk("pre_poll_wait", (cyc - hs_cyc) > 93, 1'b1);
        snap = dig_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", dig_valid, 1'b1);
            chk("stall_data", dig_data, snap);
            chk("stall_blk_ready", blk_ready, 1'b0);
            chk("stall_cs", cs, 1'b0);
        end
        chk("hs_blk_ready", blk_ready, 1'b0);
        dig_ready = 1'b1;
        exp = '0;
        if (sb_q.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
        else begin
            exp = sb_q.pop_front();
            chk("digest", dig_data, exp);
        end
        @(negedge clk);
        dig_ready = 1'b0;
        chk("post_valid", dig_valid, 1'b0);
        chk("post_blk_ready", blk_ready, 1'b1);
        chk("post_hold", dig_data, exp);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cs", cs, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_addr", address, 8'h0);
        chk("rst_wdata", write_data, 32'h0);
        chk("rst_dig_valid", dig_valid, 1'b0);
        chk("rst_dig_data", dig_data, 256'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_blk_ready", blk_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] last_dig;
        rst = 1'b1; p_rst = 1'b1; stuck = 1'b0;
        blk_valid = 1'b0; blk_data = '0; blk_init = 1'b0; dig_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0; p_rst = 1'b0;
        @(negedge clk);
        chk("idle_blk_ready", blk_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);

        send_blk(ABC_BLK, 1'b1, ABC_DIG, 1'b1);
        recv_dig(0, 93);

        // Back-pressure with a new request already waiting; it is taken only after the handshake.
        send_blk(ABC_BLK, 1'b1, ABC_DIG, 1'b1);
        blk_valid = 1'b1; blk_data = ABC_BLK; blk_init = 1'b1;
        recv_dig(20, 93);
        send_blk(ABC_BLK, 1'b1, ABC_DIG, 1'b1);
        recv_dig(0, 93);

        send_blk(M1_BLK, 1'b1, sha_comp(IV, M1_BLK), 1'b1);
        recv_dig(0, 93);
        send_blk(M2_BLK, 1'b0, TWO_DIG, 1'b1);
        recv_dig(0, 93);
        repeat (5) @(negedge clk);
        chk("dig_hold_idle", dig_data, TWO_DIG);

        // Reset mid-POLL while the peripheral is still in rounds.
        send_blk(ABC_BLK, 1'b1, ABC_DIG, 1'b1);
        repeat (38) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        sb_q.delete(sb_q.size() - 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_blk(ABC_BLK, 1'b1, ABC_DIG, 1'b1);
        recv_dig(0, 0);
        last_dig = dig_data;

        // STATUS stuck at not-ready.
        stuck = 1'b1;
        send_blk(ABC_BLK, 1'b1, 256'h0, 1'b0);
`ifdef SHA256_DRV_TIMEOUT_EN
        begin
            int n = 0;
            bit dv_seen = 1'b0;
            while (!err && n < 400) begin
                @(negedge clk);
                n++;
                if (dig_valid) dv_seen = 1'b1;
            end
            chk("err_cycle", cyc - hs_cyc, 201);
            chk("err_blk_ready", blk_ready, 1'b1);
            chk("err_busy", busy, 1'b0);
            chk("err_cs", cs, 1'b0);
            chk("err_dig_unchanged", dig_data, last_dig);
            @(negedge clk);
            chk("err_one_cycle", err, 1'b0);
            chk("err_no_dig_valid", dv_seen | dig_valid, 1'b0);
        end
`else
        begin
            bit bad = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (!busy || dig_valid || err) bad = 1'b1;
            end
            chk("stuck_stays_busy", bad, 1'b0);
            chk("stuck_dig_unchanged", dig_data, last_dig);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
`endif
        stuck = 1'b0;
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        chk("ctrl_q_empty", ctrl_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
